// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and M-stage data accesses.
// Optional stall performance counters are enabled by defining ARB_PERF_EN.
module imem_dmem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [15:0]       if_stall_cnt,
    output logic [15:0]       mem_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_hold_q, mem_hold_q;
    logic                grant_if, grant_mem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // The requester completing this cycle is never considered, so the other side wins back-to-back.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req)     grant_mem = 1'b1;
                else if (if_req) grant_if  = 1'b1;
            end
            IF_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (mem_req) grant_mem = 1'b1;
                    else         state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MEM_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (if_req) grant_if = 1'b1;
                    else        state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_mem) begin
            state_d = MEM_BUSY;
            cnt_d   = CNT_INIT;
            addr_d  = mem_addr;
            we_d    = mem_we;
            wdata_d = mem_wdata;
        end
        if (grant_if) begin
            state_d = IF_BUSY;
            cnt_d   = CNT_INIT;
            addr_d  = if_addr;
            we_d    = 1'b0;
        end
    end

    assign ram_en    = (state_q != IDLE);
    assign ram_we    = (state_q == MEM_BUSY) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign if_done   = (state_q == IF_BUSY)  && (cnt_q == 4'd0);
    assign mem_done  = (state_q == MEM_BUSY) && (cnt_q == 4'd0);
    assign if_stall  = if_req  && !if_done;
    assign mem_stall = mem_req && !mem_done;

    // Store completions leave the load hold register untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_hold_q  <= '0;
            mem_hold_q <= '0;
        end else begin
            if (if_done)             if_hold_q  <= ram_rdata;
            if (mem_done && !we_q)   mem_hold_q <= ram_rdata;
        end
    end

    assign if_rdata  = if_done ? ram_rdata : if_hold_q;
    assign mem_rdata = (mem_done && !we_q) ? ram_rdata : mem_hold_q;

`ifdef ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (if_stall && (if_stall_cnt != 16'hFFFF))
                if_stall_cnt <= if_stall_cnt + 16'd1;
            if (mem_stall && (mem_stall_cnt != 16'hFFFF))
                mem_stall_cnt <= mem_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter (LATENCY=2); perf counters checked under ARB_PERF_EN.
module tb_imem_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
`ifdef ARB_PERF_EN
    logic [15:0] if_stall_cnt;
    logic [15:0] mem_stall_cnt;
`endif

    int checks;
    int failures;

    imem_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef ARB_PERF_EN
        ,
        .if_stall_cnt  (if_stall_cnt),
        .mem_stall_cnt (mem_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 16'h0100;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        ram_rdata = 16'h0000;

        // Reset held with IF request pending
        #1;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_if_stall", if_stall, 1);
        tick();
        tick();
        chk("rst_ram_en2", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
        chk("rst_ram_wdata", ram_wdata, 16'h0000);
        chk("rst_if_rdata", if_rdata, 16'h0000);
        chk("rst_mem_rdata", mem_rdata, 16'h0000);
        chk("rst_if_done", if_done, 0);
        chk("rst_mem_done", mem_done, 0);
        chk("rst_if_stall2", if_stall, 1);

        // Release: IDLE, IF_BUSY, IF_BUSY+done
        reset = 1'b1;
        #1;
        chk("t1_idle_en", ram_en, 0);
        tick();
        chk("t1_busy_en", ram_en, 1);
        chk("t1_busy_addr", ram_addr, 16'h0100);
        chk("t1_busy_we", ram_we, 0);
        chk("t1_busy_done", if_done, 0);
        tick();
        ram_rdata = 16'h1234;
        #1;
        chk("t1_if_done", if_done, 1);
        chk("t1_if_rdata", if_rdata, 16'h1234);
        chk("t1_if_stall", if_stall, 0);
        if_req    = 1'b0;
        tick();
        ram_rdata = 16'h0000;
        #1;
        chk("t1_done_gone", if_done, 0);
        chk("t1_if_hold", if_rdata, 16'h1234);
        chk("t1_idle_again", ram_en, 0);
`ifdef ARB_PERF_EN
        chk("t1_if_stall_cnt", if_stall_cnt, 16'd2);
`endif

        // Store from IDLE
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 16'h0040;
        mem_wdata = 16'hBEEF;
        #1;
        chk("t2_mem_stall", mem_stall, 1);
        tick();
        chk("t2_c1_we", ram_we, 1);
        chk("t2_c1_addr", ram_addr, 16'h0040);
        chk("t2_c1_wdata", ram_wdata, 16'hBEEF);
        chk("t2_c1_done", mem_done, 0);
        tick();
        ram_rdata = 16'h5555;
        #1;
        chk("t2_c2_we", ram_we, 1);
        chk("t2_c2_addr", ram_addr, 16'h0040);
        chk("t2_c2_wdata", ram_wdata, 16'hBEEF);
        chk("t2_c2_done", mem_done, 1);
        chk("t2_rdata_kept", mem_rdata, 16'h0000);
        chk("t2_mem_stall_low", mem_stall, 0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        chk("t2_idle_en", ram_en, 0);
        chk("t2_rdata_after", mem_rdata, 16'h0000);

        // Simultaneous requests: MEM first, then IF with no bubble
        if_req   = 1'b1;
        if_addr  = 16'h0200;
        mem_req  = 1'b1;
        mem_addr = 16'h0300;
        #1;
        chk("t3_a_if_stall", if_stall, 1);
        tick();
        chk("t3_b_addr", ram_addr, 16'h0300);
        chk("t3_b_if_stall", if_stall, 1);
        tick();
        ram_rdata = 16'hA5A5;
        #1;
        chk("t3_c_mem_done", mem_done, 1);
        chk("t3_c_mem_rdata", mem_rdata, 16'hA5A5);
        chk("t3_c_if_done", if_done, 0);
        chk("t3_c_if_stall", if_stall, 1);
        mem_req = 1'b0;
        tick();
        chk("t3_d_en", ram_en, 1);
        chk("t3_d_addr", ram_addr, 16'h0200);
        chk("t3_d_mem_hold", mem_rdata, 16'hA5A5);
        chk("t3_d_if_stall", if_stall, 1);
        tick();
        ram_rdata = 16'h5A5A;
        #1;
        chk("t3_e_if_done", if_done, 1);
        chk("t3_e_if_rdata", if_rdata, 16'h5A5A);
        chk("t3_e_if_stall", if_stall, 0);
        if_req = 1'b0;
        tick();
        chk("t3_idle_en", ram_en, 0);

        // Continuous requests strictly alternate MEM, IF, MEM, IF
        ram_rdata = 16'h7777;
        mem_req   = 1'b1;
        mem_addr  = 16'h0400;
        if_req    = 1'b1;
        if_addr   = 16'h0500;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            chk("t4_owner_addr", ram_addr, (k % 2 == 0) ? 16'h0400 : 16'h0500);
            chk("t4_no_done", {mem_done, if_done}, 2'b00);
            tick();
            chk("t4_done", {mem_done, if_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        tick();
        chk("t4_idle_en", ram_en, 0);
        chk("t4_mem_hold", mem_rdata, 16'h7777);

        // Reset mid-MEM_BUSY aborts without done, then the held request is re-served
        mem_req  = 1'b1;
        mem_addr = 16'h0600;
        tick();
        chk("t5_busy_en", ram_en, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_en", ram_en, 0);
        chk("t5_no_done", mem_done, 0);
        chk("t5_mem_rdata", mem_rdata, 16'h0000);
        chk("t5_if_rdata", if_rdata, 16'h0000);
        chk("t5_mem_stall", mem_stall, 1);
        tick();
        chk("t5_still_no_done", mem_done, 0);
        chk("t5_still_off", ram_en, 0);
        reset = 1'b1;
        #1;
        chk("t5_idle_en", ram_en, 0);
        tick();
        chk("t5_reserve_addr", ram_addr, 16'h0600);
        chk("t5_reserve_en", ram_en, 1);
        tick();
        ram_rdata = 16'h0BAD;
        #1;
        chk("t5_done", mem_done, 1);
        chk("t5_rdata", mem_rdata, 16'h0BAD);
        mem_req = 1'b0;
        tick();
        chk("t5_idle_after", ram_en, 0);

`ifdef ARB_PERF_EN
        // Long contention run: both stall counters reach saturation
        if_req  = 1'b1;
        mem_req = 1'b1;
        repeat (88000) @(posedge clock);
        #1;
        chk("perf_if_sat", if_stall_cnt, 16'hFFFF);
        chk("perf_mem_sat", mem_stall_cnt, 16'hFFFF);
        repeat (10) tick();
        chk("perf_if_hold", if_stall_cnt, 16'hFFFF);
        if_req  = 1'b0;
        mem_req = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
